// File: rtl/rom_bus_pkg.sv
// rtl/rom_bus_pkg.sv - shared types, latency bounds and address helper for rom_bus_ctrl
package rom_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    PREF = 2'd3
  } state_e;

  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 2;

  // Next word address inside a width-bit space, wrapping all-ones to zero.
  function automatic logic [31:0] addr_inc(input logic [31:0] addr, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (addr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/rom_prefetch_buf.sv
// rtl/rom_prefetch_buf.sv - one-entry speculative read buffer, built only with ROM_PREFETCH_EN
`ifdef ROM_PREFETCH_EN
module rom_prefetch_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic                  launch_i,
  input  logic [ADDR_WIDTH-1:0] launch_tag_i,
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  clr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] tag_q;
  logic [DATA_WIDTH-1:0] data_q;

  // A launch retags the entry and invalidates it until the ROM data lands.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (launch_i) begin
      valid_q <= 1'b0;
      tag_q   <= launch_tag_i;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      data_q  <= fill_data_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_addr_i);
  assign data_o = data_q;

endmodule
`endif

// File: rtl/rom_bus_ctrl.sv
// rtl/rom_bus_ctrl.sv - 65C02 read-bus to synchronous ROM adapter with RDY stall; ROM_PREFETCH_EN adds next-address prefetch
module rom_bus_ctrl
  import rom_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_cs,
  input  logic                  cpu_rwb,
  output logic                  cpu_rdy,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  generate
    if (ROM_LATENCY < ROM_LAT_MIN || ROM_LATENCY > ROM_LAT_MAX) begin : g_bad_latency
      $error("rom_bus_ctrl: ROM_LATENCY must be 1 or 2");
    end
  endgenerate

  localparam logic [1:0] LAT = 2'(ROM_LATENCY);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_req;

  assign rd_req = cpu_cs & cpu_rwb;

`ifdef ROM_PREFETCH_EN
  logic                  pf_hit, pf_launch, pf_fill, pf_clr;
  logic [DATA_WIDTH-1:0] pf_data;

  rom_prefetch_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_prefetch_buf (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .lookup_addr_i(cpu_addr),
    .launch_i     (pf_launch),
    .launch_tag_i (rom_addr_d),
    .fill_i       (pf_fill),
    .fill_data_i  (rom_data),
    .clr_i        (pf_clr),
    .hit_o        (pf_hit),
    .data_o       (pf_data)
  );

  assign cpu_data = (state_q == IDLE && rd_req && pf_hit) ? pf_data : data_q;
`else
  assign cpu_data = data_q;
`endif

  assign rom_addr = rom_addr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    cpu_rdy    = 1'b1;
`ifdef ROM_PREFETCH_EN
    pf_launch  = 1'b0;
    pf_fill    = 1'b0;
    pf_clr     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ROM_PREFETCH_EN
        if (rd_req && pf_hit) begin
          rom_addr_d = ADDR_WIDTH'(addr_inc(32'(cpu_addr), ADDR_WIDTH));
          cnt_d      = LAT;
          pf_launch  = 1'b1;
          state_d    = PREF;
        end else
`endif
        if (rd_req) begin
          cpu_rdy    = 1'b0;
          rom_addr_d = cpu_addr;
          cnt_d      = LAT;
          state_d    = WAIT;
`ifdef ROM_PREFETCH_EN
          pf_clr     = 1'b1;
`endif
        end
      end
      // Bus inputs are deliberately ignored here; the read always lands in data_q.
      WAIT: begin
        cpu_rdy = 1'b0;
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          data_d  = rom_data;
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef ROM_PREFETCH_EN
        rom_addr_d = ADDR_WIDTH'(addr_inc(32'(rom_addr_q), ADDR_WIDTH));
        cnt_d      = LAT;
        pf_launch  = 1'b1;
        state_d    = PREF;
`else
        state_d = IDLE;
`endif
      end
`ifdef ROM_PREFETCH_EN
      PREF: begin
        cpu_rdy = ~rd_req;
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          pf_fill = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      rom_addr_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
    end
  end

endmodule
